// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble).
// One magnitude bit enters the BCD scratch register per clock. A conversion
// takes N SHIFT cycles. It is followed by a single DONE cycle that carries the
// result-valid pulse. Signed inputs are converted as sign plus magnitude.
module binary_to_bcd_seq #(
  parameter int N      = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                signed_mode,
  input  logic [N-1:0]        bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                neg
);

  // The counter reaches N on the final shift, so it needs room for N itself.
  localparam int CW = $clog2(N + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state_q;
  logic [N-1:0]    mag_q;
  logic [BW-1:0]   digits_q;
  logic [CW-1:0]   cnt_q;
  logic            negNext_q;
  logic            busy_q;
  logic            done_q;
  logic [BW-1:0]   bcd_q;
  logic            neg_q;

  logic [BW-1:0]   digitsAdj;
  logic [BW-1:0]   digitsShift_d;
  logic [N-1:0]    magShift_d;
  logic [N-1:0]    magLoad_d;
  logic            negLoad_d;

  // Add 3 to each digit that is 5 or more, then shift the digits and magnitude left by one.
  always_comb begin
    digitsAdj = digits_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits_q[4*i +: 4] >= 4'd5) begin
        digitsAdj[4*i +: 4] = digits_q[4*i +: 4] + 4'd3;
      end
    end
    digitsShift_d = {digitsAdj[BW-2:0], mag_q[N-1]};
    magShift_d    = mag_q << 1;
  end

  // Form the sign and magnitude at capture. The most negative value maps to 2^(N-1), and zero is never negative.
  always_comb begin
    negLoad_d = signed_mode & bin[N-1];
    magLoad_d = negLoad_d ? (N'(0) - bin) : bin;
  end

  // Control FSM and datapath registers. Every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mag_q     <= '0;
      digits_q  <= '0;
      cnt_q     <= '0;
      negNext_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            mag_q     <= magLoad_d;
            negNext_q <= negLoad_d;
            digits_q  <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          digits_q <= digitsShift_d;
          mag_q    <= magShift_d;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            bcd_q   <= digitsShift_d;
            neg_q   <= negNext_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign neg  = neg_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed testbench for binary_to_bcd_seq with N=8 and DIGITS=3.
// Each scenario task drives its own stimulus and checks results inline.
module tb_binary_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic        neg;

  int checks;
  int failures;

  binary_to_bcd_seq #(.N(8), .DIGITS(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .bin         (bin),
    .busy        (busy),
    .done        (done),
    .bcd         (bcd),
    .neg         (neg)
  );

  // 10 ns clock. Inputs change and outputs are sampled on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: sign and decimal digits computed arithmetically.
  function automatic logic [12:0] refConv(input logic [7:0] v, input bit m);
    int val;
    int h;
    int t;
    int o;
    bit n;
    n   = m && v[7];
    val = n ? (256 - int'(v)) : int'(v);
    h   = val / 100;
    t   = (val / 10) % 10;
    o   = val % 10;
    return {n, 4'(h), 4'(t), 4'(o)};
  endfunction

  // Pulse start for one capture edge and return on the falling edge just after capture.
  task automatic pulseStart(input logic [7:0] v, input bit m);
    @(negedge clk);
    bin         = v;
    signed_mode = m;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Run one conversion and observe the outputs over 12 falling edges.
  // doneAt is the falling-edge index of the first done pulse (1 = just after capture).
  task automatic runConv(input logic [7:0] v, input bit m,
                         output int busyCnt, output int doneAt, output int doneCnt,
                         output logic [11:0] bcdAt, output logic negAt, output bit stableOk);
    logic [11:0] prevBcd;
    logic        prevNeg;
    pulseStart(v, m);
    prevBcd  = bcd;
    prevNeg  = neg;
    busyCnt  = 0;
    doneAt   = -1;
    doneCnt  = 0;
    bcdAt    = 'x;
    negAt    = 1'bx;
    stableOk = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        if (doneAt < 0) begin
          doneAt = i;
          bcdAt  = bcd;
          negAt  = neg;
        end
      end else if (doneAt < 0 && (bcd !== prevBcd || neg !== prevNeg)) begin
        stableOk = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    start       = 1'b0;
    signed_mode = 1'b0;
    bin         = 8'h00;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    checks++;
    if (bcd !== 12'h000) begin failures++; $display("[TB] FAIL reset_bcd got=%h want=000", bcd); end
    checks++;
    if (neg !== 1'b0) begin failures++; $display("[TB] FAIL reset_neg got=%b want=0", neg); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned_max();
    int busyCnt, doneAt, doneCnt;
    logic [11:0] b;
    logic n;
    bit st;
    runConv(8'hFF, 1'b0, busyCnt, doneAt, doneCnt, b, n, st);
    checks++;
    if (busyCnt !== 8) begin failures++; $display("[TB] FAIL ff_busy_cycles got=%0d want=8", busyCnt); end
    checks++;
    if (doneAt !== 9) begin failures++; $display("[TB] FAIL ff_done_latency got=%0d want=9", doneAt); end
    checks++;
    if (doneCnt !== 1) begin failures++; $display("[TB] FAIL ff_done_count got=%0d want=1", doneCnt); end
    checks++;
    if (b !== 12'h255) begin failures++; $display("[TB] FAIL ff_bcd got=%h want=255", b); end
    checks++;
    if (n !== 1'b0) begin failures++; $display("[TB] FAIL ff_neg got=%b want=0", n); end
    checks++;
    if (st !== 1'b1) begin failures++; $display("[TB] FAIL ff_stable got=%b want=1", st); end
  endtask

  task automatic test_signed();
    logic [7:0]  vin   [4] = '{8'h80, 8'hF6, 8'h00, 8'h80};
    bit          vmode [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [11:0] vbcd  [4] = '{12'h128, 12'h010, 12'h000, 12'h128};
    logic        vneg  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int busyCnt, doneAt, doneCnt;
    logic [11:0] b;
    logic n;
    bit st;
    for (int k = 0; k < 4; k++) begin
      runConv(vin[k], vmode[k], busyCnt, doneAt, doneCnt, b, n, st);
      checks++;
      if (b !== vbcd[k]) begin
        failures++;
        $display("[TB] FAIL signed_bcd in=%h mode=%0d got=%h want=%h", vin[k], vmode[k], b, vbcd[k]);
      end
      checks++;
      if (n !== vneg[k]) begin
        failures++;
        $display("[TB] FAIL signed_neg in=%h mode=%0d got=%b want=%b", vin[k], vmode[k], n, vneg[k]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int doneCnt;
    logic [11:0] b;
    pulseStart(8'h2A, 1'b0);
    doneCnt = 0;
    b       = 'x;
    for (int i = 1; i <= 15; i++) begin
      if (done) begin
        doneCnt++;
        b = bcd;
      end
      if (i == 3) begin
        bin         = 8'h63;
        signed_mode = 1'b1;
        start       = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    signed_mode = 1'b0;
    checks++;
    if (doneCnt !== 1) begin failures++; $display("[TB] FAIL ignore_done_count got=%0d want=1", doneCnt); end
    checks++;
    if (b !== 12'h042) begin failures++; $display("[TB] FAIL ignore_bcd got=%h want=042", b); end
  endtask

  task automatic test_reset_abort();
    int doneCnt;
    int busyCnt, doneAt, dc;
    logic [11:0] b;
    logic n;
    bit st;
    pulseStart(8'hC8, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy got=%b want=0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL abort_done got=%b want=0", done); end
    checks++;
    if (bcd !== 12'h000) begin failures++; $display("[TB] FAIL abort_bcd got=%h want=000", bcd); end
    @(negedge clk);
    rst     = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    checks++;
    if (doneCnt !== 0) begin failures++; $display("[TB] FAIL abort_no_done got=%0d want=0", doneCnt); end
    runConv(8'hC8, 1'b0, busyCnt, doneAt, dc, b, n, st);
    checks++;
    if (b !== 12'h200) begin failures++; $display("[TB] FAIL abort_restart_bcd got=%h want=200", b); end
    checks++;
    if (doneAt !== 9) begin failures++; $display("[TB] FAIL abort_restart_latency got=%0d want=9", doneAt); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] want [3] = '{12'h009, 12'h010, 12'h099};
    logic [11:0] got  [3];
    int          idx  [3];
    int          n;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      got[k] = 'x;
      idx[k] = -100;
    end
    @(negedge clk);
    bin         = 8'h09;
    signed_mode = 1'b0;
    start       = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done && n < 3) begin
        got[n] = bcd;
        idx[n] = i;
        n++;
        if (n == 1) bin = 8'h0A;
        else if (n == 2) bin = 8'h63;
        else start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (n !== 3) begin failures++; $display("[TB] FAIL b2b_result_count got=%0d want=3", n); end
    checks++;
    if (idx[0] !== 9) begin failures++; $display("[TB] FAIL b2b_first_latency got=%0d want=9", idx[0]); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got[k] !== want[k]) begin
        failures++;
        $display("[TB] FAIL b2b_bcd[%0d] got=%h want=%h", k, got[k], want[k]);
      end
    end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (idx[k] - idx[k-1] !== 9) begin
        failures++;
        $display("[TB] FAIL b2b_period[%0d] got=%0d want=9", k, idx[k] - idx[k-1]);
      end
    end
  endtask

  task automatic test_sweep();
    int busyCnt, doneAt, doneCnt;
    logic [11:0] b;
    logic n;
    bit st;
    logic [12:0] exp;
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 256; v++) begin
        runConv(8'(v), m[0], busyCnt, doneAt, doneCnt, b, n, st);
        exp = refConv(8'(v), m[0]);
        checks++;
        if (b !== exp[11:0]) begin
          failures++;
          $display("[TB] FAIL sweep_bcd in=%h mode=%0d got=%h want=%h", v[7:0], m, b, exp[11:0]);
        end
        checks++;
        if (n !== exp[12]) begin
          failures++;
          $display("[TB] FAIL sweep_neg in=%h mode=%0d got=%b want=%b", v[7:0], m, n, exp[12]);
        end
        checks++;
        if (doneAt !== 9) begin
          failures++;
          $display("[TB] FAIL sweep_latency in=%h mode=%0d got=%0d want=9", v[7:0], m, doneAt);
        end
        checks++;
        if (st !== 1'b1) begin
          failures++;
          $display("[TB] FAIL sweep_stable in=%h mode=%0d got=%b want=1", v[7:0], m, st);
        end
      end
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_unsigned_max();
    test_signed();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd_seq.md
BINARY_TO_BCD_SEQ -- requirements
Module: binary_to_bcd_seq

Purpose: downstream of the N-bit accumulator. Converts the accumulator sum, unsigned or two's complement, to packed BCD digits for the hex display decoders. Uses iterative shift-add-3 (double dabble), one bit per clock.

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the binary input width.
REQ-002 The block SHALL have parameter DIGITS, default 3, giving the BCD output digit count; DIGITS SHALL satisfy 10^DIGITS > 2^N.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: conversion request.
REQ-006 The block SHALL have port signed_mode, input, 1 bit: 1 means bin is two's complement.
REQ-007 The block SHALL have port bin, input, N bits: value to convert.
REQ-008 The block SHALL have port busy, output, 1 bit: conversion in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-010 The block SHALL have port bcd, output, 4*DIGITS bits: packed BCD, most significant digit in the top nibble.
REQ-011 The block SHALL have port neg, output, 1 bit: result sign, 1 means negative.

Function
REQ-012 The block SHALL implement states IDLE, SHIFT and DONE, with all outputs registered.
REQ-013 The block SHALL sample start only in IDLE or DONE; start seen at edge k SHALL capture bin and signed_mode, clear the scratch digits and bit count, and enter SHIFT.
REQ-014 At capture, the block SHALL load the magnitude (-bin mod 2^N when signed_mode=1 and bin[N-1]=1, else bin) and register the sign into an internal neg_next.
REQ-015 Each SHIFT cycle SHALL first add 3 to every scratch digit >= 5, then shift the {digits, magnitude} register left by 1.
REQ-016 The N-th shift SHALL occur at edge k+N; at that same edge the block SHALL load bcd from the scratch digits, load neg from neg_next, and enter DONE.
REQ-017 busy SHALL be 1 exactly while state is SHIFT, i.e. for N cycles after edge k.
REQ-018 done SHALL be 1 exactly while state is DONE, for one cycle; latency from the start edge to done SHALL be N cycles.
REQ-019 From DONE, the block SHALL go to SHIFT if start=1, else to IDLE; a continuously held start SHALL therefore give one result every N+1 cycles.
REQ-020 start while busy=1 SHALL be ignored, and changes to bin or signed_mode after capture SHALL NOT affect the result in flight.
REQ-021 bcd and neg SHALL hold the last completed result until the next done, and SHALL NOT change during SHIFT.
REQ-022 The most negative signed value SHALL be handled: bin = 2^(N-1) with signed_mode=1 SHALL convert to magnitude 2^(N-1) with neg=1.
REQ-023 Zero SHALL always give neg=0, including in signed mode.
REQ-024 The internal bit counter SHALL be ceil(log2(N+1)) bits wide and SHALL NOT wrap within a conversion.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for a clock edge, force state IDLE, busy=0, done=0, bcd=0, neg=0, and clear the scratch register and counter.
REQ-026 Reset during SHIFT SHALL abort the conversion with no done pulse; the first start after rst falls SHALL convert normally.

Verification
REQ-027 Unsigned bin=8'hFF, signed_mode=0, one-cycle start -> busy high for 8 cycles, done after 8 cycles, bcd=12'h255, neg=0.
REQ-028 Signed cases -> bin=8'h80 gives bcd=12'h128, neg=1; bin=8'hF6 gives bcd=12'h010, neg=1; bin=8'h00 gives bcd=12'h000, neg=0.
REQ-029 start with bin=8'h2A, then start pulsed with bin=8'h63 at cycle 3 of busy -> second start ignored, done once with bcd=12'h042.
REQ-030 rst pulsed during cycle 4 of a conversion of 8'hC8 -> busy and done low immediately, bcd=12'h000, no done pulse; a following start with 8'hC8 gives bcd=12'h200.
REQ-031 start held high with bin stepping 8'h09, 8'h0A, 8'h63 -> done every 9 cycles, giving bcd 12'h009, 12'h010, 12'h099 in order.
REQ-032 Exhaustive sweep of all 256 values in both modes -> every result matches a reference model, and bcd is stable between done pulses.
